// File: rtl/decode_dispatch.sv
// rtl/decode_dispatch.sv - multi-lane decode, in-order dispatch and HLT/INT/flush sequencing
package nand_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_CL   = 3'd0,
    ALU_CP   = 3'd1,
    ALU_NAND = 3'd2,
    ALU_LS   = 3'd3,
    ALU_RS   = 3'd4,
    ALU_EQ   = 3'd5,
    ALU_NE   = 3'd6,
    ALU_LI   = 3'd7
  } AluOp;
endpackage

module decode_dispatch
  import nand_cpu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         fetch_valid,
  input  logic [$clog2(LANES+1)-1:0]   fetch_count,
  input  logic [8*LANES-1:0]           fetch_instr,
  output logic                         fetch_ready,
  output logic                         ex_valid,
  input  logic                         ex_ready,
  output logic [7:0]                   ex_instr,
  output logic [TAG_W-1:0]             ex_tag,
  output logic [11:0]                  ex_ctrl,
  output AluOp                         ex_alu_op,
  output logic                         st_valid,
  input  logic                         st_ready,
  output logic [7:0]                   st_instr,
  output logic [TAG_W-1:0]             st_tag,
  output logic [11:0]                  st_ctrl,
  output logic                         ld_valid,
  input  logic                         ld_ready,
  output logic [7:0]                   ld_instr,
  output logic [TAG_W-1:0]             ld_tag,
  output logic [11:0]                  ld_ctrl,
  output logic                         br_valid,
  input  logic                         br_ready,
  output logic [7:0]                   br_instr,
  output logic [TAG_W-1:0]             br_tag,
  output logic [11:0]                  br_ctrl,
  input  logic                         flush,
  input  logic                         int_done,
  input  logic                         resume,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int CW = $clog2(LANES + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [1:0] P_EX = 2'd0;
  localparam logic [1:0] P_ST = 2'd1;
  localparam logic [1:0] P_LD = 2'd2;
  localparam logic [1:0] P_BR = 2'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_INT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  port;
    logic        hlt;
    logic        is_int;
    logic [11:0] ctrl;
    AluOp        op;
  } dec_t;

  // ctrl = {use_ra, use_rt, use_rw, use_rs, use_immdt, mem_access, jump, branch, rw_addr}
  function automatic dec_t decode(input logic [7:0] i);
    dec_t d;
    d.port   = P_EX;
    d.hlt    = 1'b0;
    d.is_int = 1'b0;
    d.ctrl   = '0;
    d.op     = ALU_CL;
    casez (i)
      8'h00:        d.ctrl = 12'b0010_0000_0000;
      8'b0000_????: begin d.ctrl = {8'b1010_0000, i[3:0]}; d.op = ALU_CP; end
      8'b0001_????: begin d.ctrl = 12'b1110_0000_0000; d.op = ALU_NAND; end
      8'b0010_????: begin d.ctrl = 12'b1110_0000_0000; d.op = ALU_LS; end
      8'b0011_????: begin d.ctrl = 12'b1110_0000_0000; d.op = ALU_RS; end
      8'b0100_????: begin d.ctrl = 12'b1101_0000_0000; d.op = ALU_EQ; end
      8'b0101_????: begin d.ctrl = 12'b1101_0000_0000; d.op = ALU_NE; end
      8'b0110_????: begin d.ctrl = 12'b0100_0001_0000; d.port = P_BR; end
      8'b0111_????: begin d.ctrl = {8'b0110_0010, i[3:0]}; d.port = P_BR; end
      8'b10??_????: begin d.ctrl = 12'b1010_1000_0000; d.op = ALU_LI; end
      8'b1100_????: begin d.ctrl = 12'b0110_0100_0000; d.port = P_LD; end
      8'b1101_????: begin d.ctrl = 12'b1100_0100_0000; d.port = P_ST; end
      8'b1110_????: begin d.ctrl = 12'b0000_1000_0000; d.port = P_BR; d.is_int = 1'b1; end
      default:      d.hlt = 1'b1;
    endcase
    return d;
  endfunction

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]    occ_q;
  logic [TAG_W-1:0] tag_q;
  state_t           state_q, state_d;

  logic [3:0]       rdy;
  logic [3:0]       pv;
  logic [7:0]       pinstr [4];
  logic [TAG_W-1:0] ptag [4];
  logic [11:0]      pctrl [4];
  AluOp             alu_d;
  logic [CW-1:0]    npop, nenq;
  logic [TAG_W-1:0] tag_inc;
  logic             stop;
  logic [7:0]       ent;
  dec_t             d;

  assign rdy         = {br_ready, ld_ready, st_ready, ex_ready};
  assign fetch_ready = (state_q == RUN) && !flush && (occ_q <= OW'(DEPTH - LANES));
  assign nenq        = !(fetch_valid && fetch_ready) ? '0 :
                       (fetch_count > CW'(LANES)) ? CW'(LANES) : fetch_count;
  assign occupancy   = occ_q;
  assign halted      = (state_q == HALTED);

  assign ex_valid = pv[P_EX]; assign ex_instr = pinstr[P_EX];
  assign ex_tag   = ptag[P_EX]; assign ex_ctrl = pctrl[P_EX]; assign ex_alu_op = alu_d;
  assign st_valid = pv[P_ST]; assign st_instr = pinstr[P_ST];
  assign st_tag   = ptag[P_ST]; assign st_ctrl = pctrl[P_ST];
  assign ld_valid = pv[P_LD]; assign ld_instr = pinstr[P_LD];
  assign ld_tag   = ptag[P_LD]; assign ld_ctrl = pctrl[P_LD];
  assign br_valid = pv[P_BR]; assign br_instr = pinstr[P_BR];
  assign br_tag   = ptag[P_BR]; assign br_ctrl = pctrl[P_BR];

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= RUN;
    else        state_q <= state_d;
  end

  // In-order scan of the head window: steer, tag, count pops, and pick next state
  always_comb begin
    state_d = state_q;
    pv      = '0;
    alu_d   = ALU_CL;
    npop    = '0;
    tag_inc = '0;
    stop    = 1'b0;
    ent     = '0;
    d       = '0;
    for (int p = 0; p < 4; p++) begin
      pinstr[p] = '0;
      ptag[p]   = '0;
      pctrl[p]  = '0;
    end
    unique case (state_q)
      RUN: begin
        if (!flush) begin
          for (int i = 0; i < LANES; i++) begin
            if (!stop && (OW'(i) < occ_q)) begin
              ent = mem[rd_ptr_q + PW'(i)];
              d   = decode(ent);
              if (d.hlt) begin
                // HLT only retires from the head; deeper in the window it just blocks
                stop = 1'b1;
                if (i == 0) begin
                  npop    = CW'(1);
                  state_d = HALTED;
                end
              end else if (pv[d.port] || !rdy[d.port]) begin
                stop = 1'b1;
              end else begin
                pv[d.port]     = 1'b1;
                pinstr[d.port] = ent;
                ptag[d.port]   = tag_q + tag_inc;
                pctrl[d.port]  = d.ctrl;
                if (d.port == P_EX) alu_d = d.op;
                tag_inc = tag_inc + 1'b1;
                npop    = npop + 1'b1;
                if (d.is_int) begin
                  stop    = 1'b1;
                  state_d = WAIT_INT;
                end
              end
            end
          end
        end
      end
      WAIT_INT: if (int_done || flush) state_d = RUN;
      HALTED:   if (resume && !flush) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Queue pointers, occupancy and sequence tag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      tag_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(npop);
      wr_ptr_q <= wr_ptr_q + PW'(nenq);
      occ_q    <= occ_q + OW'(nenq) - OW'(npop);
      tag_q    <= tag_q + tag_inc;
    end
  end

  // Queue storage; contents are only read below the occupancy mark, so no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < nenq) mem[wr_ptr_q + PW'(i)] <= fetch_instr[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_decode_dispatch.sv
// tb/tb_decode_dispatch.sv - randomized and directed bench for decode_dispatch with a queue model
module tb_decode_dispatch;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;

  logic clk = 0, n_rst = 0;
  logic fetch_valid = 0, fetch_ready;
  logic [1:0] fetch_count = 0;
  logic [15:0] fetch_instr = 0;
  logic ex_valid, st_valid, ld_valid, br_valid;
  logic ex_ready = 0, st_ready = 0, ld_ready = 0, br_ready = 0;
  logic [7:0] ex_instr, st_instr, ld_instr, br_instr;
  logic [3:0] ex_tag, st_tag, ld_tag, br_tag;
  logic [11:0] ex_ctrl, st_ctrl, ld_ctrl, br_ctrl;
  nand_cpu_pkg::AluOp ex_alu_op;
  logic flush = 0, int_done = 0, resume = 0, halted;
  logic [3:0] occupancy;

  decode_dispatch #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .n_rst(n_rst), .fetch_valid(fetch_valid), .fetch_count(fetch_count),
    .fetch_instr(fetch_instr), .fetch_ready(fetch_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr), .ex_tag(ex_tag),
    .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op),
    .st_valid(st_valid), .st_ready(st_ready), .st_instr(st_instr), .st_tag(st_tag), .st_ctrl(st_ctrl),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_instr(ld_instr), .ld_tag(ld_tag), .ld_ctrl(ld_ctrl),
    .br_valid(br_valid), .br_ready(br_ready), .br_instr(br_instr), .br_tag(br_tag), .br_ctrl(br_ctrl),
    .flush(flush), .int_done(int_done), .resume(resume), .halted(halted), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  int mtag = 0;
  int mst = 0;  // 0 run, 1 waiting for int_done, 2 halted

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
    end
  endtask

  // Reference decode from the instruction table: 0 EX, 1 ST, 2 LD, 3 BR, -1 HLT
  function automatic int port_of(input logic [7:0] x);
    case (x[7:4])
      4'hC: return 2;
      4'hD: return 1;
      4'h6, 4'h7, 4'hE: return 3;
      4'hF: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [11:0] ctrl_of(input logic [7:0] x);
    bit ra = 0, rt = 0, rw = 0, rs = 0, im = 0, mem = 0, jmp = 0, br = 0;
    logic [3:0] wa = 0;
    int op = x[7:4];
    if (x == 8'h00) rw = 1;
    else if (op == 0) begin ra = 1; rw = 1; wa = x[3:0]; end
    else if (op >= 1 && op <= 3) begin ra = 1; rt = 1; rw = 1; end
    else if (op == 4 || op == 5) begin ra = 1; rt = 1; rs = 1; end
    else if (op == 6) begin rt = 1; br = 1; end
    else if (op == 7) begin rt = 1; rw = 1; jmp = 1; wa = x[3:0]; end
    else if (op >= 8 && op <= 11) begin ra = 1; rw = 1; im = 1; end
    else if (op == 12) begin rt = 1; rw = 1; mem = 1; end
    else if (op == 13) begin ra = 1; rt = 1; mem = 1; end
    else if (op == 14) im = 1;
    return {ra, rt, rw, rs, im, mem, jmp, br, wa};
  endfunction

  function automatic int alu_of(input logic [7:0] x);
    if (x == 8'h00) return 0;       // CL
    if (x[7:6] == 2'b10) return 7;  // LI
    case (x[7:4])
      4'h0: return 1;
      4'h1: return 2;
      4'h2: return 3;
      4'h3: return 4;
      4'h4: return 5;
      default: return 6;
    endcase
  endfunction

  // One clock: drive, check against the model, advance the model, cross the edge
  task automatic step(input bit fv, input int fc, input logic [15:0] fi,
                      input logic [3:0] rdy, input bit fl, input bit idn, input bit res);
    logic [24:0] exp_b [4];
    logic [24:0] got_b [4];
    bit used [4];
    int pops, newst, ntag, p, exp_alu;
    bit exp_fr;
    logic [7:0] ins;
    fetch_valid = fv; fetch_count = 2'(fc); fetch_instr = fi;
    {br_ready, ld_ready, st_ready, ex_ready} = rdy;
    flush = fl; int_done = idn; resume = res;
    #1;
    for (int k = 0; k < 4; k++) begin exp_b[k] = '0; used[k] = 0; end
    pops = 0; newst = mst; ntag = mtag; exp_alu = -1;
    exp_fr = (mst == 0) && !fl && (DEPTH - q.size() >= LANES);
    if (mst == 0 && !fl) begin
      for (int i = 0; i < LANES && i < q.size(); i++) begin
        ins = q[i];
        p = port_of(ins);
        if (p < 0) begin
          if (i == 0) begin pops = 1; newst = 2; end
          break;
        end
        if (used[p] || !rdy[p]) break;
        used[p] = 1;
        exp_b[p] = {1'b1, ins, 4'(ntag % 16), ctrl_of(ins)};
        if (p == 0) exp_alu = alu_of(ins);
        ntag = (ntag + 1) % (1 << TAG_W);
        pops++;
        if (ins[7:4] == 4'hE) begin newst = 1; break; end
      end
    end else if (mst == 1 && (idn || fl)) newst = 0;
    else if (mst == 2 && res && !fl) newst = 0;
    got_b[0] = {ex_valid, ex_instr, ex_tag, ex_ctrl};
    got_b[1] = {st_valid, st_instr, st_tag, st_ctrl};
    got_b[2] = {ld_valid, ld_instr, ld_tag, ld_ctrl};
    got_b[3] = {br_valid, br_instr, br_tag, br_ctrl};
    chk("ex_port", 32'(got_b[0]), 32'(exp_b[0]));
    chk("st_port", 32'(got_b[1]), 32'(exp_b[1]));
    chk("ld_port", 32'(got_b[2]), 32'(exp_b[2]));
    chk("br_port", 32'(got_b[3]), 32'(exp_b[3]));
    if (exp_alu >= 0) chk("alu_op", 32'(ex_alu_op), 32'(exp_alu));
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("halted", 32'(halted), 32'(mst == 2));
    if (fl) q.delete();
    else begin
      for (int i = 0; i < pops; i++) void'(q.pop_front());
      if (fv && exp_fr)
        for (int i = 0; i < fc && i < LANES; i++) q.push_back(fi[8*i +: 8]);
    end
    if (!fl) mtag = ntag;
    mst = newst;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [3:0] rdy);
    step(0, 0, 16'h0, rdy, 0, 0, 0);
  endtask

  logic [7:0] r0, r1;

  initial begin
    #1;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_fready", 32'(fetch_ready), 1);
    chk("rst_valids", 32'({ex_valid, st_valid, ld_valid, br_valid}), 0);
    chk("rst_halted", 32'(halted), 0);
    #3 n_rst = 1;
    @(posedge clk); #1;

    // NND + LD dispatched together
    step(1, 2, 16'hC3_15, 4'hF, 0, 0, 0);
    idle(4'hF); idle(4'hF);
    // two EX in consecutive cycles, then stalled EX
    step(1, 2, 16'h34_12, 4'hF, 0, 0, 0);
    idle(4'hF); idle(4'hF);
    step(1, 2, 16'h34_12, 4'hE, 0, 0, 0);
    repeat (3) idle(4'hE);
    repeat (3) idle(4'hF);
    // ST held behind a stalled BR
    step(1, 2, 16'hD5_60, 4'h7, 0, 0, 0);
    repeat (2) idle(4'h7);
    idle(4'hF);
    // HLT then resume
    step(1, 2, 16'h11_F0, 4'hF, 0, 0, 0);
    idle(4'hF);
    chk("hlt_halted", 32'(halted), 1);
    idle(4'hF);
    step(0, 0, 16'h0, 4'hF, 0, 0, 1);
    idle(4'hF); idle(4'hF);
    // INT then int_done
    step(1, 2, 16'h13_E2, 4'hF, 0, 0, 0);
    idle(4'hF); idle(4'hF);
    step(0, 0, 16'h0, 4'hF, 0, 1, 0);
    idle(4'hF); idle(4'hF);
    // fill to DEPTH, then flush
    for (int i = 0; i < 4; i++) step(1, 2, {8'(8'h20 + i), 8'(8'h40 + i)}, 4'h0, 0, 0, 0);
    chk("full_fready", 32'(fetch_ready), 0);
    step(1, 2, 16'h11_11, 4'hF, 1, 0, 0);
    idle(4'hF);
    // fill and drain repeatedly so pointers wrap
    for (int k = 0; k < 12; k++) begin
      r0 = 8'($urandom_range(8'h10, 8'hDF)); r1 = 8'($urandom_range(8'h10, 8'hDF));
      step(1, 2, {r1, r0}, 4'h0, 0, 0, 0);
      idle(4'hF);
    end
    repeat (6) idle(4'hF);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r0 = 8'($urandom); r1 = 8'($urandom);
      if (r0[7:5] == 3'b111 && $urandom_range(0, 2) != 0) r0[7] = 1'b0;
      if (r1[7:5] == 3'b111 && $urandom_range(0, 2) != 0) r1[7] = 1'b0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, LANES), {r1, r0},
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
           $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // asynchronous reset mid-operation
    step(1, 2, 16'h22_21, 4'h0, 0, 0, 0);
    fetch_valid = 0; flush = 0; {br_ready, ld_ready, st_ready, ex_ready} = 4'hF;
    #2 n_rst = 0; #1;
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_valids", 32'({ex_valid, st_valid, ld_valid, br_valid}), 0);
    chk("arst_ex", 32'({ex_instr, ex_tag, ex_ctrl}), 0);
    chk("arst_fready", 32'(fetch_ready), 1);
    q.delete(); mtag = 0; mst = 0;
    #1 n_rst = 1;
    @(posedge clk); #1;
    step(1, 2, 16'hC4_16, 4'hF, 0, 0, 0);
    idle(4'hF); idle(4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_dispatch.md
# decode_dispatch

Parametrised multi-lane decode and dispatch stage for the out-of-order core. It sits between fetch and the EX/ST/LD/BR issue buffers. It queues fetched 8-bit instructions, decodes up to LANES of them per cycle in program order, and steers each one to its buffer over a valid/ready port with a wrapping sequence tag. It also sequences HLT, INT and pipeline flush through a small state machine.

## Interface
- LANES, 2: instructions accepted and decoded per cycle (1-4)
- DEPTH, 8: instruction queue entries (power of 2, DEPTH >= LANES)
- TAG_W, 4: sequence tag width
- clk  in  1  clock
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- fetch_valid  in  1  fetch bundle present
- fetch_count  in  $clog2(LANES+1)  valid lanes in bundle; lane 0 is oldest
- fetch_instr  in  8*LANES  lane i in bits [8i+7:8i]
- fetch_ready  out  1  queue has >= LANES free entries, state is RUN, and flush is low
- ex_/st_/ld_/br_valid  out  1 each  dispatch strobe per buffer
- ex_/st_/ld_/br_ready  in  1 each  buffer can accept
- ex_/st_/ld_/br_instr  out  8 each  raw instruction
- ex_/st_/ld_/br_tag  out  TAG_W each  sequence tag
- ex_/st_/ld_/br_ctrl  out  12 each  {use_ra, use_rt, use_rw, use_rs, use_immdt, mem_access, jump, branch, rw_addr[3:0]}
- ex_alu_op  out  nand_cpu_pkg::AluOp  EX operation
- flush  in  1  discard all queued instructions
- int_done  in  1  interrupt serviced
- resume  in  1  leave HALTED
- halted  out  1  state == HALTED
- occupancy  out  $clog2(DEPTH+1)  queued entries

## Operation
- Decode table (instr): 0x00 CL EX rw; 0000xxxx CP EX ra,rw, rw_addr=instr[3:0]; 0001 NND, 0010 LS, 0011 RS EX ra,rt,rw; 0100 EQ, 0101 NE EX ra,rt,rs; 0110 BR BR rt,branch; 0111 JRL BR rt,rw,jump, rw_addr=instr[3:0]; 10xxxxxx LI EX ra,rw,immdt; 1100 LD LD rt,rw,mem_access; 1101 ST ST ra,rt,mem_access; 1110 INT BR immdt; 1111 HLT, not dispatched.
- rw_addr is 0 unless stated otherwise. Unused ctrl bits are 0. ex_alu_op is ALU_CL/CP/NAND/LS/RS/EQ/NE/LI to match the decode table.
- Dispatch scan runs over the oldest min(LANES, occupancy) entries, in order. Each port accepts at most one instruction per cycle.
- The scan stops at the first instruction whose target port is already used this cycle or whose ready is low. Younger entries wait.
- A dispatched entry is popped when its valid&ready is high. A HLT at the head of the scanned window is popped without dispatch and ends the scan.
- Tag counter starts at 0. It increments by 1 per dispatched instruction (HLT excluded) and wraps modulo 2^TAG_W. Tags within a cycle are assigned in lane order.
- Enqueue happens when fetch_valid&fetch_ready. fetch_count entries are written. fetch_count=0 is a no-op.
- FSM:
  - RUN: normal operation. A popped HLT moves to HALTED. An INT dispatched on BR moves to WAIT_INT and ends the scan for that cycle.
  - WAIT_INT: no dispatch, no enqueue. int_done moves to RUN.
  - HALTED: no dispatch, no enqueue. resume moves to RUN.
- flush: the queue empties at the next edge, that cycle's dispatch is suppressed (all valid outputs 0), and fetch_ready=0.
  - The tag counter is unchanged.
  - flush in WAIT_INT moves to RUN. flush in HALTED stays HALTED.

## Timing
- Reset: queue empty, occupancy=0, tag=0, state RUN, halted=0, every *_valid=0, every *_instr/tag/ctrl=0, fetch_ready=1.
- Fetch-to-dispatch latency is 1 cycle: an entry enqueued at edge N can present *_valid in cycle N+1.
- Dispatch outputs are combinational from the queue head and the state. Ready-to-valid has no combinational path through the enqueue logic.
- Simultaneous enqueue and pop in one cycle update occupancy by enqueued minus popped. Pointers wrap modulo DEPTH.
- halted rises the cycle after the edge that popped the HLT. halted falls the cycle after resume is sampled.
- If n_rst is asserted mid-operation, it clears everything asynchronously. No partial dispatch survives.

## Test plan
- LANES=2, bundle {0x15 NND, 0xC3 LD}, all ready -> next cycle ex_valid and ld_valid together, tags 0 and 1, occupancy returns to 0.
- Bundle {0x12, 0x34}, both EX -> 0x12 dispatched in cycle 1 with tag 0, 0x34 in cycle 2 with tag 1. With ex_ready=0 for 3 cycles, no pops and no tag advance.
- Bundle {0x60 BR, 0xD5 ST} with br_ready=0 -> neither dispatches, because ST is held behind BR. Raising br_ready dispatches both in the same cycle.
- {0xF0, 0x11} -> HLT popped, halted=1 next cycle, 0x11 stays queued with fetch_ready=0. resume -> RUN, 0x11 dispatches with the next tag.
- {0xE2 INT, 0x13} -> br_valid with ctrl use_immdt=1, then state WAIT_INT, 0x13 held. int_done -> 0x13 dispatches.
- Fill to DEPTH=8 -> fetch_ready=0. Then flush -> occupancy=0 next cycle, no valid pulses, tags continue from the pre-flush value. Fill to wrap pointers twice, and FIFO order is preserved.
